timer_counter: RTL and testbench
================================

# timer_counter

Memory-mapped programmable down-counter that generates the CPU's external `interrupt` request, sitting directly upstream of `mips` on the system bridge. The CPU programs it through three word registers (CTRL, PRESET, COUNT); the counter loads PRESET, counts to zero and raises `irq`, either one-shot or auto-reloading. `irq` drives the `interrupt` input of `mips`.

## Interface
- `WIDTH`, 32, width of PRESET and COUNT

- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `addr`  in  32  byte address; only `addr[3:2]` decoded (0=CTRL at 0x0, 1=PRESET at 0x4, 2=COUNT at 0x8, 3=reserved)
- `we`  in  1  write strobe, sampled on rising edge
- `wdata`  in  32  write data
- `rdata`  out  32  combinational read of the selected register; reserved reads 0
- `irq`  out  1  interrupt request = `CTRL.IM & irq_flag`

## Operation
- CTRL bits: [0] EN, [2:1] MODE (0=one-shot, 1=auto-reload, 2/3 behave as 0), [3] IM; bits [31:4] read 0, writes ignored.
- PRESET: fully writable, `WIDTH` bits, zero-extended on read. COUNT: read-only, writes ignored.
- FSM states IDLE, LOAD, CNT, INT:
  - IDLE: EN=1 -> LOAD, else stay.
  - LOAD: COUNT <= PRESET -> CNT.
  - CNT: EN=0 -> IDLE, COUNT held; else COUNT>1 -> COUNT-1, stay; else COUNT <= 0 -> INT, irq_flag <= 1 on that edge.
  - INT, mode 0: CTRL.EN <= 0, irq_flag held -> IDLE. irq_flag stays 1 until the next CPU write to CTRL.
  - INT, mode 1: irq_flag <= 0 -> IDLE; EN still 1, so counter reloads.
- PRESET write mid-count: no effect on COUNT until next LOAD.
- CTRL write mid-count: new EN/MODE/IM visible on the following cycle; clearing EN stops in CNT within one edge.
- Simultaneous CPU CTRL write and hardware EN clear (INT, mode 0): CPU write value wins.
- Simultaneous irq_flag set (CNT->INT) and CTRL-write clear: set wins.
- PRESET=0 behaves like PRESET=1 (count never underflows; no wrap).

## Timing
- Reset: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state IDLE, `irq`=0; `rdata`=0 for all addresses.
- Write on edge E0 setting EN with PRESET=P: LOAD after E1, COUNT=P after E2, `irq` high after edge E(max(P,1)+2).
- Mode 1 period: successive `irq` pulses P+3 cycles apart (P≥1), each pulse exactly one cycle wide.
- `rdata` has zero-cycle latency; COUNT reads reflect the value after the most recent edge.
- Reset asserted in any state returns everything to reset values on that edge; no pending `irq` survives.

## Configuration
- `TC_MODE1_EN`: defined -> auto-reload mode 1 implemented as above. Undefined -> MODE field is read-as-written but every mode behaves as mode 0 (one-shot, EN cleared in INT).

## Structure
- Shared package `tc_pkg`: register offsets (CTRL/PRESET/COUNT), CTRL bit positions, MODE codes, FSM state encoding.
- Single module; no sub-module is warranted (register file and counter share the FSM tightly).

## Test plan
- Reset, read 0x0/0x4/0x8 -> all 0, `irq`=0.
- PRESET=5, CTRL=0x9 (EN, mode 0, IM) -> `irq` rises exactly 7 edges after CTRL write, stays high; CTRL.EN reads 0; write CTRL=0 -> `irq` low next cycle.
- PRESET=3, CTRL=0xB (mode 1, IM, `TC_MODE1_EN` defined) -> one-cycle `irq` pulses every 6 cycles; with macro undefined -> single pulse held high, EN cleared.
- Mode 0, P=10, clear EN after 4 decrements -> COUNT freezes at 6, no `irq`; re-enable -> reload to 10.
- CTRL IM=0, P=2 -> irq_flag internally set, `irq` stays 0; then set IM=1 -> `irq`=1.
- Assert `reset` for one cycle mid-count (COUNT=4) -> all registers 0, state IDLE, `irq`=0 next cycle.

Source files
------------

// File: rtl/tc_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : tc_pkg
//  Brief     : Shared definitions for timer_counter: register offsets, CTRL
//              bit positions, MODE codes and FSM state encoding.
//  Revision  : 1.0 - initial release
// ============================================================================
package tc_pkg;

  // Register select codes, taken from addr[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // CTRL bit positions; bits above CTRL_BITS-1 do not exist and read 0
  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;
  localparam int CTRL_BITS     = 4;

  // MODE codes; the two remaining codes act as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  // Counter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
//  Module    : timer_counter
//  Brief     : Memory-mapped programmable down-counter (CTRL/PRESET/COUNT)
//              producing the CPU interrupt request, one-shot or auto-reload.
//  Config    : TC_MODE1_EN - when defined, MODE=1 auto-reloads; otherwise
//              every MODE value behaves as one-shot (MODE still read back).
//  Revision  : 1.0 - initial release
// ============================================================================
module timer_counter
  import tc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_t               state;
  state_t               state_next;
  logic [CTRL_BITS-1:0] ctrl;
  logic [WIDTH-1:0]     preset;
  logic [WIDTH-1:0]     count;
  logic [WIDTH-1:0]     count_next;
  logic                 irq_flag;
  logic                 flag_set;
  logic                 flag_hw_clr;
  logic                 en_hw_clr;
  logic                 reload;
  logic [1:0]           reg_sel;
  logic                 ctrl_wr;
  logic                 preset_wr;

  // Only the word select bits take part in decoding
  logic unused_addr;
  assign unused_addr = ^{addr[31:4], addr[1:0]};

  assign reg_sel   = addr[3:2];
  assign ctrl_wr   = we && (reg_sel == REG_CTRL);
  assign preset_wr = we && (reg_sel == REG_PRESET);

`ifdef TC_MODE1_EN
  assign reload = (ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_RELOAD);
`else
  assign reload = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state and counter/flag control decisions
  always_comb begin
    state_next  = state;
    count_next  = count;
    flag_set    = 1'b0;
    flag_hw_clr = 1'b0;
    en_hw_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctrl[CTRL_EN]) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        count_next = preset;
        state_next = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl[CTRL_EN]) begin
          state_next = ST_IDLE;
        end else if (count > WIDTH'(1)) begin
          count_next = count - WIDTH'(1);
        end else begin
          // Terminal count covers PRESET=0 too, so COUNT never wraps
          count_next = '0;
          state_next = ST_INT;
          flag_set   = 1'b1;
        end
      end
      ST_INT: begin
        state_next = ST_IDLE;
        if (reload) flag_hw_clr = 1'b1;
        else        en_hw_clr   = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Register file, counter and interrupt flag; CPU CTRL writes beat the
  // hardware EN clear, while a flag set beats the clear caused by a CTRL write
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      count <= count_next;
      if (preset_wr) preset <= wdata[WIDTH-1:0];
      if (ctrl_wr)        ctrl <= wdata[CTRL_BITS-1:0];
      else if (en_hw_clr) ctrl[CTRL_EN] <= 1'b0;
      if (flag_set)                      irq_flag <= 1'b1;
      else if (ctrl_wr || flag_hw_clr)   irq_flag <= 1'b0;
    end
  end

  // Zero-latency register read; reserved slot reads 0
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL:   rdata = 32'(ctrl);
      REG_PRESET: rdata = 32'(preset);
      REG_COUNT:  rdata = 32'(count);
      default:    rdata = '0;
    endcase
  end

  assign irq = ctrl[CTRL_IM] & irq_flag;

endmodule
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// ============================================================================
//  Module    : tb_timer_counter
//  Brief     : Scoreboard bench for timer_counter: directed scenarios plus
//              randomized runs against an arithmetic reference model.
//  Config    : honours TC_MODE1_EN the same way as the design.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_timer_counter;

  localparam int WIDTH = 32;
  localparam logic [31:0] A_CTRL = 32'h0;
  localparam logic [31:0] A_PRE  = 32'h4;
  localparam logic [31:0] A_CNT  = 32'h8;
  localparam logic [31:0] A_RSV  = 32'hC;
`ifdef TC_MODE1_EN
  localparam bit MODE1_OK = 1'b1;
`else
  localparam bit MODE1_OK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  timer_counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  logic chk_valid = 1'b0;
  int   n_checks  = 0;
  int   n_fail    = 0;

  // Monitor: each observed cycle pops one expectation and compares it
  always @(negedge clk) begin
    if (chk_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: observed cycle at %0t had no expectation", $time);
      end else begin
        cur = exp_q.pop_front();
        n_checks++;
        if (rdata !== cur.rdata) begin
          n_fail++;
          $display("FAIL %s rdata: got %h, expected %h (addr %h, t=%0t)",
                   cur.tag, rdata, cur.rdata, addr, $time);
        end
        n_checks++;
        if (irq !== cur.irq) begin
          n_fail++;
          $display("FAIL %s irq: got %b, expected %b (t=%0t)", cur.tag, irq, cur.irq, $time);
        end
      end
    end
  end

  // One clock cycle of stimulus; the optional expectation describes what the
  // DUT shows during this cycle, before the inputs are sampled at its end
  task automatic step(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic chk,
                      input logic [31:0] er, input logic ei, input string tag);
    reset     = r;
    we        = w;
    addr      = a;
    wdata     = d;
    chk_valid = chk;
    if (chk) exp_q.push_back('{tag, er, ei});
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] a, input logic [31:0] er, input logic ei,
                      input string tag);
    step(1'b0, 1'b0, a, 32'h0, 1'b1, er, ei, tag);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, a, d, 1'b0, 32'h0, 1'b0, "");
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, A_CTRL, 32'h0, 1'b0, 32'h0, 1'b0, "");
  endtask

  // Reference model: what a read of address a returns, and the irq level,
  // s edges after the enabling CTRL write, for a counter started from reset.
  // Start-up is 2 edges; one-shot fires max(P,1) edges later and holds;
  // auto-reload repeats every max(P,1)+3 edges with one-cycle pulses.
  function automatic void model(input int s, input int p, input logic [1:0] mode,
                                input logic im, input logic [31:0] a,
                                output logic [31:0] er, output logic ei);
    bit rl;
    bit en;
    int pe;
    int per;
    int u;
    int cnt;
    rl  = MODE1_OK && (mode == 2'd1);
    pe  = (p < 1) ? 1 : p;
    per = pe + 3;
    u   = (s < 2) ? -1 : (rl ? (s - 2) % per : s - 2);
    cnt = (s < 2) ? 0 : ((p > u) ? p - u : 0);
    en  = rl ? 1'b1 : (s < pe + 3);
    ei  = im && (rl ? (u == pe) : (s >= pe + 2));
    case (a[3:2])
      2'd0:    er = {28'd0, im, mode, en};
      2'd1:    er = 32'(p);
      2'd2:    er = 32'(cnt);
      default: er = 32'h0;
    endcase
  endfunction

  task automatic model_run(input int p, input logic [1:0] mode, input logic im,
                           input int ncyc, input bit rand_addr, input string tag);
    logic [31:0] a;
    logic [31:0] er;
    logic        ei;
    do_reset();
    wr(A_PRE, 32'(p));
    wr(A_CTRL, {28'd0, im, mode, 1'b1});
    for (int s = 0; s < ncyc; s++) begin
      a = rand_addr ? $urandom : A_CNT;
      model(s, p, mode, im, a, er, ei);
      look(a, er, ei, tag);
    end
  endtask

  initial begin
    int p;
    int pe;
    logic [1:0] mode;
    logic im;

    reset = 1'b1;
    we    = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    do_reset();
    do_reset();

    // Reset state: every register reads 0, irq low
    look(A_CTRL, 32'h0, 1'b0, "reset_ctrl");
    look(A_PRE,  32'h0, 1'b0, "reset_preset");
    look(A_CNT,  32'h0, 1'b0, "reset_count");
    look(A_RSV,  32'h0, 1'b0, "reset_rsvd");

    // One-shot P=5 with IM: irq at edge 7, held; EN self-clears; CTRL write drops irq
    model_run(5, 2'd0, 1'b1, 12, 1'b0, "oneshot_p5");
    look(A_CTRL, 32'h8, 1'b1, "oneshot_en_cleared");
    wr(A_CTRL, 32'h0);
    look(A_CTRL, 32'h0, 1'b0, "oneshot_irq_clear");
    look(A_CNT,  32'h0, 1'b0, "oneshot_idle");

    // MODE=1, P=3: periodic one-cycle pulses (or held one-shot without reload)
    model_run(3, 2'd1, 1'b1, 20, 1'b0, "mode1_p3");
    look(A_CTRL, MODE1_OK ? 32'hB : 32'hA, MODE1_OK ? 1'b0 : 1'b1, "mode1_ctrl");

    // Clear EN after four decrements: COUNT freezes at 6, then reloads to 10
    do_reset();
    wr(A_PRE, 32'd10);
    wr(A_CTRL, 32'h9);
    look(A_CNT, 32'd0,  1'b0, "freeze_s0");
    look(A_CNT, 32'd0,  1'b0, "freeze_s1");
    look(A_CNT, 32'd10, 1'b0, "freeze_load");
    look(A_CNT, 32'd9,  1'b0, "freeze_s3");
    look(A_CNT, 32'd8,  1'b0, "freeze_s4");
    step(1'b0, 1'b1, A_CTRL, 32'h8, 1'b1, 32'h9, 1'b0, "freeze_wr");
    for (int i = 0; i < 5; i++) look(A_CNT, 32'd6, 1'b0, "freeze_held");
    look(A_CTRL, 32'h8, 1'b0, "freeze_ctrl");
    wr(A_CTRL, 32'h9);
    look(A_CNT, 32'd6,  1'b0, "reenable_s0");
    look(A_CNT, 32'd6,  1'b0, "reenable_s1");
    look(A_CNT, 32'd10, 1'b0, "reenable_reload");
    look(A_CNT, 32'd9,  1'b0, "reenable_dec");

    // IM=0, P=2: no irq; IM set by a write landing on the flag-setting edge,
    // so the set survives the write and irq appears immediately
    do_reset();
    wr(A_PRE, 32'd2);
    wr(A_CTRL, 32'h1);
    look(A_CNT, 32'd0, 1'b0, "mask_s0");
    look(A_CNT, 32'd0, 1'b0, "mask_s1");
    look(A_CNT, 32'd2, 1'b0, "mask_s2");
    step(1'b0, 1'b1, A_CTRL, 32'h9, 1'b1, 32'h1, 1'b0, "mask_wr");
    look(A_CTRL, 32'h9, 1'b1, "mask_set_wins");
    look(A_CTRL, 32'h8, 1'b1, "mask_en_cleared");
    look(A_CNT,  32'h0, 1'b1, "mask_held");

    // CPU CTRL write on the INT edge beats the hardware EN clear
    do_reset();
    wr(A_PRE, 32'd1);
    wr(A_CTRL, 32'h9);
    look(A_CNT, 32'd0, 1'b0, "cpuwin_s0");
    look(A_CNT, 32'd0, 1'b0, "cpuwin_s1");
    look(A_CNT, 32'd1, 1'b0, "cpuwin_s2");
    step(1'b0, 1'b1, A_CTRL, 32'h9, 1'b1, 32'h9, 1'b1, "cpuwin_wr");
    look(A_CTRL, 32'h9, 1'b0, "cpuwin_ctrl");
    look(A_CNT,  32'd0, 1'b0, "cpuwin_s5");
    look(A_CNT,  32'd1, 1'b0, "cpuwin_reload");
    look(A_CNT,  32'd0, 1'b1, "cpuwin_irq");

    // Reset mid-count at COUNT=4 clears everything, no restart afterwards
    do_reset();
    wr(A_PRE, 32'd10);
    wr(A_CTRL, 32'h9);
    for (int s = 0; s < 8; s++)
      look(A_CNT, (s < 2) ? 32'd0 : 32'(12 - s), 1'b0, "midreset_count");
    step(1'b1, 1'b0, A_CNT, 32'h0, 1'b1, 32'd4, 1'b0, "midreset_pre");
    look(A_CTRL, 32'h0, 1'b0, "midreset_ctrl");
    look(A_PRE,  32'h0, 1'b0, "midreset_preset");
    look(A_RSV,  32'h0, 1'b0, "midreset_rsvd");
    for (int i = 0; i < 4; i++) look(A_CNT, 32'h0, 1'b0, "midreset_count0");

    // Randomized runs: random PRESET, MODE, IM and read addresses
    for (int t = 0; t < 30; t++) begin
      p    = $urandom_range(0, 12);
      mode = 2'($urandom_range(0, 3));
      im   = 1'($urandom_range(0, 1));
      pe   = (p < 1) ? 1 : p;
      model_run(p, mode, im, 2 * (pe + 3) + 3, 1'b1, "rand");
    end

    chk_valid = 1'b0;
    we        = 1'b0;
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
